// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one load/store request at a time through a
// single-cycle memory port (IDLE -> ACCESS -> RESP). Requests use big-endian
// byte lanes. Misaligned and illegal requests are answered with an exception
// code and never touch memory.
//
// Optional feature: define LLSC_EN to enable the load-linked (op 8) and
// store-conditional (op 9) operations and the link bit. When it is undefined,
// ops 8 and 9 are illegal, llbit_o is tied to 0 and llbit_clr is ignored.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_op              0 LB,1 LBU,2 LH,3 LHU,4 LW,5 SB,6 SH,7 SW,8 LL,9 SC
//   req_addr            byte address
//   req_wdata           store data (low bits significant)
//   req_wd              destination register
//   resp_valid          one-cycle completion pulse
//   resp_rdata          load data / SC success flag
//   resp_wd, resp_wreg  destination register and write-enable
//   resp_exc            00 none, 01 load misaligned, 10 store misaligned, 11 illegal
//   mem_ce, mem_we      memory enable / write enable (ACCESS state only)
//   mem_sel             byte lanes, bit 3 = addr[1:0]==00
//   mem_addr            word-aligned address
//   mem_data_o          replicated store data
//   mem_data_i          combinational read data
//   llbit_clr, llbit_o  link bit clear input and current link bit
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_wd,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_wd,
  output logic              resp_wreg,
  output logic [1:0]        resp_exc,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [3:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_o,
  input  logic [31:0]       mem_data_i,
  input  logic              llbit_clr,
  output logic              llbit_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [3:0]        op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [4:0]        wd_r;

  logic        is_load_s, is_store_s, is_byte_s, is_half_s, is_word_s;
  logic        is_sext_s, is_ll_s, is_sc_s, illegal_s, misalign_s, sc_fail_s;
  logic [1:0]  exc_s;
  logic        go_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_data_s;
  logic        llbit_r;

  logic        resp_valid_r, resp_wreg_r;
  logic [31:0] resp_rdata_r;
  logic [4:0]  resp_wd_r;
  logic [1:0]  resp_exc_r;

  // State register; reset from any state returns to IDLE and drops the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS:  state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request capture on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r    <= 4'd0;
      addr_r  <= '0;
      wdata_r <= 32'd0;
      wd_r    <= 5'd0;
    end else if (state_r == IDLE && req_valid) begin
      op_r    <= req_op;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      wd_r    <= req_wd;
    end
  end

  // Opcode decode into class, access size and extension.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    is_byte_s  = 1'b0;
    is_half_s  = 1'b0;
    is_word_s  = 1'b0;
    is_sext_s  = 1'b0;
    is_ll_s    = 1'b0;
    is_sc_s    = 1'b0;
    illegal_s  = 1'b0;
    case (op_r)
      4'd0: begin is_load_s  = 1'b1; is_byte_s = 1'b1; is_sext_s = 1'b1; end
      4'd1: begin is_load_s  = 1'b1; is_byte_s = 1'b1; end
      4'd2: begin is_load_s  = 1'b1; is_half_s = 1'b1; is_sext_s = 1'b1; end
      4'd3: begin is_load_s  = 1'b1; is_half_s = 1'b1; end
      4'd4: begin is_load_s  = 1'b1; is_word_s = 1'b1; end
      4'd5: begin is_store_s = 1'b1; is_byte_s = 1'b1; end
      4'd6: begin is_store_s = 1'b1; is_half_s = 1'b1; end
      4'd7: begin is_store_s = 1'b1; is_word_s = 1'b1; end
`ifdef LLSC_EN
      4'd8: begin is_load_s  = 1'b1; is_word_s = 1'b1; is_ll_s = 1'b1; end
      4'd9: begin is_store_s = 1'b1; is_word_s = 1'b1; is_sc_s = 1'b1; end
`endif
      default: illegal_s = 1'b1;
    endcase
  end

  // Exception classification; illegal takes priority over misalignment.
  always_comb begin
    misalign_s = (is_half_s & addr_r[0]) | (is_word_s & (addr_r[1:0] != 2'b00));
    if (illegal_s) begin
      exc_s = 2'b11;
    end else if (misalign_s && is_load_s) begin
      exc_s = 2'b01;
    end else if (misalign_s) begin
      exc_s = 2'b10;
    end else begin
      exc_s = 2'b00;
    end
  end

`ifdef LLSC_EN
  assign sc_fail_s = is_sc_s & ~llbit_r;
`else
  assign sc_fail_s = 1'b0;
`endif

  // Memory is touched only in ACCESS for clean requests; rst gates it so a
  // reset landing on a store cycle cannot commit the write.
  assign go_s = (state_r == ACCESS) & (exc_s == 2'b00) & ~sc_fail_s & ~rst;

  // Memory port drive: big-endian lane select and replicated store data.
  always_comb begin
    mem_ce     = 1'b0;
    mem_we     = 1'b0;
    mem_sel    = 4'b0000;
    mem_addr   = '0;
    mem_data_o = 32'd0;
    if (go_s) begin
      mem_ce   = 1'b1;
      mem_we   = is_store_s;
      mem_addr = {addr_r[ADDR_W-1:2], 2'b00};
      if (is_byte_s) begin
        mem_sel    = 4'b1000 >> addr_r[1:0];
        mem_data_o = {4{wdata_r[7:0]}};
      end else if (is_half_s) begin
        mem_sel    = addr_r[1] ? 4'b0011 : 4'b1100;
        mem_data_o = {2{wdata_r[15:0]}};
      end else begin
        mem_sel    = 4'b1111;
        mem_data_o = wdata_r;
      end
    end else begin
      mem_ce = 1'b0;
    end
  end

  // Load lane extraction from read data (lane 0 = bits 31:24).
  always_comb begin
    case (addr_r[1:0])
      2'b00:   byte_s = mem_data_i[31:24];
      2'b01:   byte_s = mem_data_i[23:16];
      2'b10:   byte_s = mem_data_i[15:8];
      2'b11:   byte_s = mem_data_i[7:0];
      default: byte_s = 8'd0;
    endcase
    half_s = addr_r[1] ? mem_data_i[15:0] : mem_data_i[31:16];
    if (is_byte_s) begin
      load_data_s = {{24{is_sext_s & byte_s[7]}}, byte_s};
    end else if (is_half_s) begin
      load_data_s = {{16{is_sext_s & half_s[15]}}, half_s};
    end else begin
      load_data_s = mem_data_i;
    end
  end

  // Response registers, loaded at the end of ACCESS and held until the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_wd_r    <= 5'd0;
      resp_wreg_r  <= 1'b0;
      resp_exc_r   <= 2'b00;
    end else begin
      resp_valid_r <= (state_r == ACCESS);
      if (state_r == ACCESS) begin
        resp_wd_r   <= wd_r;
        resp_exc_r  <= exc_s;
        resp_wreg_r <= (exc_s == 2'b00) & (is_load_s | is_sc_s);
        if (exc_s != 2'b00) begin
          resp_rdata_r <= 32'd0;
        end else if (is_sc_s) begin
          resp_rdata_r <= {31'd0, ~sc_fail_s};
        end else if (is_load_s) begin
          resp_rdata_r <= load_data_s;
        end else begin
          resp_rdata_r <= 32'd0;
        end
      end
    end
  end

`ifdef LLSC_EN
  // Link bit: external clear wins over an LL set; a successful SC consumes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      llbit_r <= 1'b0;
    end else if (llbit_clr) begin
      llbit_r <= 1'b0;
    end else if (state_r == ACCESS && exc_s == 2'b00 && is_ll_s) begin
      llbit_r <= 1'b1;
    end else if (state_r == ACCESS && exc_s == 2'b00 && is_sc_s) begin
      llbit_r <= 1'b0;
    end
  end
`else
  logic llsc_unused_s;
  assign llbit_r       = 1'b0;
  assign llsc_unused_s = llbit_clr | is_ll_s;
`endif

  assign req_ready  = (state_r == IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_wd    = resp_wd_r;
  assign resp_wreg  = resp_wreg_r;
  assign resp_exc   = resp_exc_r;
  assign llbit_o    = llbit_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected responses,
// a monitor pops and compares on every resp_valid.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_wd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_wd;
  logic        resp_wreg;
  logic [1:0]  resp_exc;
  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        llbit_clr;
  logic        llbit_o;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [1:0]  exc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wd(req_wd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_wd(resp_wd),
    .resp_wreg(resp_wreg), .resp_exc(resp_exc),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .llbit_clr(llbit_clr), .llbit_o(llbit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_resp: got resp_valid=1, expected no response at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_wd", {27'd0, resp_wd}, {27'd0, e.wd});
        check("resp_wreg", {31'd0, resp_wreg}, {31'd0, e.wreg});
        check("resp_exc", {30'd0, resp_exc}, {30'd0, e.exc});
      end
    end
  end

  // Issue one request; check the ACCESS-cycle memory drive and response timing.
  task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] wd,
                        input logic [31:0] mdi,
                        input logic ce, input logic we, input logic [3:0] sel,
                        input logic [31:0] maddr, input logic [31:0] mdo,
                        input logic [31:0] rdata, input logic wreg,
                        input logic [1:0] exc);
    exp_t e;
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_wdata  = wdata;
    req_wd     = wd;
    mem_data_i = mdi;
    e.rdata = rdata; e.wd = wd; e.wreg = wreg; e.exc = exc;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ready_access", {31'd0, req_ready}, 32'd0);
    check("mem_ce", {31'd0, mem_ce}, {31'd0, ce});
    check("mem_we", {31'd0, mem_we}, {31'd0, we});
    if (ce) begin
      check("mem_sel", {28'd0, mem_sel}, {28'd0, sel});
      check("mem_addr", mem_addr, maddr);
      check("mem_data_o", mem_data_o, mdo);
    end
    check("resp_valid_early", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("resp_valid_latency", {31'd0, resp_valid}, 32'd1);
    check("mem_ce_resp", {31'd0, mem_ce}, 32'd0);
    @(negedge clk);
    check("resp_valid_pulse", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'd0;
    req_wdata = 32'd0; req_wd = 5'd0; mem_data_i = 32'd0; llbit_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_wd", {27'd0, resp_wd}, 32'd0);
    check("rst_resp_wreg", {31'd0, resp_wreg}, 32'd0);
    check("rst_resp_exc", {30'd0, resp_exc}, 32'd0);
    check("rst_llbit", {31'd0, llbit_o}, 32'd0);
    check("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_sel", {28'd0, mem_sel}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_data_o", mem_data_o, 32'd0);

    //     op     addr         wdata         wd     mdi           ce    we    sel      maddr        mdo           rdata         wreg  exc
    do_req(4'd5,  32'h13,      32'hAB,       5'd3,  32'h0,        1'b1, 1'b1, 4'b0001, 32'h10,      32'hABABABAB, 32'h0,        1'b0, 2'b00);
    do_req(4'd0,  32'h21,      32'h0,        5'd5,  32'h1280FF34, 1'b1, 1'b0, 4'b0100, 32'h20,      32'h0,        32'hFFFFFF80, 1'b1, 2'b00);
    do_req(4'd1,  32'h21,      32'h0,        5'd6,  32'h1280FF34, 1'b1, 1'b0, 4'b0100, 32'h20,      32'h0,        32'h00000080, 1'b1, 2'b00);
    do_req(4'd2,  32'h05,      32'h0,        5'd7,  32'h1280FF34, 1'b0, 1'b0, 4'b0000, 32'h0,       32'h0,        32'h0,        1'b0, 2'b01);
    do_req(4'd7,  32'h06,      32'h11223344, 5'd8,  32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,       32'h0,        32'h0,        1'b0, 2'b10);
    do_req(4'd2,  32'h22,      32'h0,        5'd9,  32'h1280FF34, 1'b1, 1'b0, 4'b0011, 32'h20,      32'h0,        32'hFFFFFF34, 1'b1, 2'b00);
    do_req(4'd3,  32'h20,      32'h0,        5'd10, 32'h80010000, 1'b1, 1'b0, 4'b1100, 32'h20,      32'h0,        32'h00008001, 1'b1, 2'b00);
    do_req(4'd4,  32'h44,      32'h0,        5'd11, 32'hDEADBEEF, 1'b1, 1'b0, 4'b1111, 32'h44,      32'h0,        32'hDEADBEEF, 1'b1, 2'b00);
    do_req(4'd6,  32'h12,      32'h12345678, 5'd12, 32'h0,        1'b1, 1'b1, 4'b0011, 32'h10,      32'h56785678, 32'h0,        1'b0, 2'b00);
    do_req(4'd7,  32'hFFFFFFF8,32'hCAFEF00D, 5'd13, 32'h0,        1'b1, 1'b1, 4'b1111, 32'hFFFFFFF8,32'hCAFEF00D, 32'h0,        1'b0, 2'b00);
    do_req(4'd0,  32'h10,      32'h0,        5'd14, 32'h7F000000, 1'b1, 1'b0, 4'b1000, 32'h10,      32'h0,        32'h0000007F, 1'b1, 2'b00);
    do_req(4'd4,  32'h03,      32'h0,        5'd15, 32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,       32'h0,        32'h0,        1'b0, 2'b01);
    do_req(4'd15, 32'h00,      32'h0,        5'd31, 32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,       32'h0,        32'h0,        1'b0, 2'b11);

`ifdef LLSC_EN
    do_req(4'd8,  32'h80,      32'h0,        5'd1,  32'h11223344, 1'b1, 1'b0, 4'b1111, 32'h80,      32'h0,        32'h11223344, 1'b1, 2'b00);
    check("llbit_after_ll", {31'd0, llbit_o}, 32'd1);
    do_req(4'd9,  32'h80,      32'h55,       5'd2,  32'h0,        1'b1, 1'b1, 4'b1111, 32'h80,      32'h00000055, 32'h1,        1'b1, 2'b00);
    check("llbit_after_sc", {31'd0, llbit_o}, 32'd0);
    do_req(4'd8,  32'h80,      32'h0,        5'd3,  32'h0,        1'b1, 1'b0, 4'b1111, 32'h80,      32'h0,        32'h0,        1'b1, 2'b00);
    @(negedge clk); llbit_clr = 1'b1;
    @(negedge clk); llbit_clr = 1'b0;
    check("llbit_after_clr", {31'd0, llbit_o}, 32'd0);
    do_req(4'd9,  32'h80,      32'h66,       5'd4,  32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,       32'h0,        32'h0,        1'b1, 2'b00);
    llbit_clr = 1'b1;
    do_req(4'd8,  32'h84,      32'h0,        5'd5,  32'hA5A5A5A5, 1'b1, 1'b0, 4'b1111, 32'h84,      32'h0,        32'hA5A5A5A5, 1'b1, 2'b00);
    llbit_clr = 1'b0;
    check("llbit_clr_wins", {31'd0, llbit_o}, 32'd0);
`else
    llbit_clr = 1'b1;
    do_req(4'd8,  32'h80,      32'h0,        5'd1,  32'h11223344, 1'b0, 1'b0, 4'b0000, 32'h0,       32'h0,        32'h0,        1'b0, 2'b11);
    do_req(4'd9,  32'h80,      32'h55,       5'd2,  32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,       32'h0,        32'h0,        1'b0, 2'b11);
    llbit_clr = 1'b0;
    check("llbit_tied", {31'd0, llbit_o}, 32'd0);
`endif

    // Reset while a store is in ACCESS: no write, no response.
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd7; req_addr = 32'h40; req_wdata = 32'h99887766; req_wd = 5'd20;
    @(negedge clk);
    req_valid = 1'b0;
    check("inflight_we_before_rst", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("inflight_we_gated", {31'd0, mem_we}, 32'd0);
    check("inflight_ce_gated", {31'd0, mem_ce}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("post_rst_resp_exc", {30'd0, resp_exc}, 32'd0);
    check("post_rst_resp_wd", {27'd0, resp_wd}, 32'd0);
    repeat (3) @(negedge clk);

    do_req(4'd4,  32'h40,      32'h0,        5'd21, 32'h01020304, 1'b1, 1'b0, 4'b1111, 32'h40,      32'h0,        32'h01020304, 1'b1, 2'b00);

    repeat (4) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: ADDR_W, 32, width of request and memory byte addresses.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  load/store request present.
REQ-005 req_ready  out  1  request accepted when req_valid&req_ready at a clk edge.
REQ-006 req_op  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW, 8 LL, 9 SC, others illegal.
REQ-007 req_addr  in  ADDR_W  byte address; req_wdata  in  32  store data (low bits significant); req_wd  in  5  destination register.
REQ-008 resp_valid  out  1  one-cycle completion pulse; resp_rdata  out  32  load/SC result; resp_wd  out  5; resp_wreg  out  1  register write required.
REQ-009 resp_exc  out  2  00 none, 01 load misaligned, 10 store misaligned, 11 illegal op.
REQ-010 mem_ce, mem_we  out  1 each  memory enable and write enable, active-high; mem_sel  out  4  byte lanes; mem_addr  out  ADDR_W  word-aligned ({req_addr[ADDR_W-1:2],2'b00}); mem_data_o  out  32; mem_data_i  in  32  combinational read data.
REQ-011 llbit_clr  in  1  clears link bit; llbit_o  out  1  current link bit.

Function
REQ-012 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accept, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-013 req_ready=1 only in IDLE; op, addr, wdata, wd latched on accept.
REQ-014 Memory driven only in ACCESS: mem_ce=1, mem_we=1 for stores, 0 for loads; all mem_* outputs 0 in other states.
REQ-015 Big-endian lanes: byte at addr[1:0]=00/01/10/11 -> sel 1000/0100/0010/0001; half at 00/10 -> 1100/0011; word -> 1111.
REQ-016 Store data replicated: SB {b,b,b,b}, SH {h,h}, SW/SC word as-is.
REQ-017 Loads capture selected lane of mem_data_i at end of ACCESS; LB/LH sign-extend, LBU/LHU zero-extend, LW/LL full word.
REQ-018 Misaligned (half with addr[0]=1, word/LL/SC with addr[1:0]!=0) or illegal op: mem_ce stays 0 in ACCESS, resp_exc set, resp_wreg=0.
REQ-019 resp_valid=1 exactly in RESP; latency accept-edge to resp_valid = 2 cycles; throughput one request per 3 cycles.
REQ-020 resp_wreg=1 for error-free loads and SC, 0 for stores; resp_rdata, resp_wd, resp_exc hold until next RESP.
REQ-021 mem_ce and mem_we gated by !rst so reset asserted during ACCESS commits no write.

Reset
REQ-022 rst at any state -> IDLE next edge; req_ready=1 after reset; resp_valid, resp_rdata, resp_wd, resp_wreg, resp_exc, llbit_o, all mem_* outputs = 0.
REQ-023 Request in flight when rst asserts is discarded; no resp_valid produced for it.

Configuration
REQ-024 Macro LLSC_EN defined: LL = LW plus llbit set to 1 at end of ACCESS; SC with llbit=1 stores word, resp_rdata=1, clears llbit; SC with llbit=0 keeps mem_ce=0, resp_rdata=0.
REQ-025 llbit_clr=1 clears llbit next edge; when coincident with LL set, clear wins.
REQ-026 LLSC_EN undefined: ops 8 and 9 are illegal (resp_exc=11), llbit_o tied 0, llbit_clr ignored.

Verification
REQ-027 SB addr 0x13, wdata 0xAB -> ACCESS: ce=1, we=1, sel=0001, mem_addr=0x10, mem_data_o=0xABABABAB; RESP resp_wreg=0, exc=00.
REQ-028 LB addr 0x21, mem_data_i=0x1280FF34 -> resp_rdata=0xFFFFFF80 two cycles after accept; LBU same -> 0x00000080.
REQ-029 LH addr 0x05 -> no ce in ACCESS, resp_exc=01, resp_wreg=0; SW addr 0x06 -> resp_exc=10, we never 1.
REQ-030 rst asserted in ACCESS of SW 0x40 -> mem_we=0 that cycle, next cycle IDLE, no resp_valid.
REQ-031 LLSC_EN: LL 0x80 then SC 0x80 -> SC writes, resp_rdata=1; LL, llbit_clr pulse, SC -> no write, resp_rdata=0; without LLSC_EN op 9 -> resp_exc=11.
